// File: rtl/window_minmax_tracker.sv
// Windowed running max/min tracker: tracks unsigned extremes over WINDOW accepted
// samples and presents the window result on a valid/ready handshake.
module window_minmax_tracker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             new_max,
    output logic             new_min,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_max,
    output logic [WIDTH-1:0] res_min,
    input  logic             res_ready
);

    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] max_next;
    logic [WIDTH-1:0] min_next;
    logic             new_max_next;
    logic             new_min_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clr aborts the window from any state
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_next = (WINDOW == 32'd1) ? REPORT : TRACK;
                    end
                end
                TRACK: begin
                    if (accept && (cnt_inc == WIN_CNT)) begin
                        state_next = REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: only the report phase stalls the producer
    always_comb begin
        in_ready = (state != REPORT);
    end

    assign accept  = in_valid && in_ready && !clr;
    assign cnt_inc = sample_cnt + CNT_W'(1);

    // Datapath next values; equal samples leave the extremes untouched
    always_comb begin
        max_next     = max_val;
        min_next     = min_val;
        cnt_next     = sample_cnt;
        new_max_next = 1'b0;
        new_min_next = 1'b0;
        if (clr) begin
            cnt_next = '0;
        end else if (accept) begin
            if (state == IDLE) begin
                max_next     = in_data;
                min_next     = in_data;
                cnt_next     = CNT_W'(1);
                new_max_next = 1'b1;
                new_min_next = 1'b1;
            end else begin
                if (in_data > max_val) begin
                    max_next     = in_data;
                    new_max_next = 1'b1;
                end
                if (in_data < min_val) begin
                    min_next     = in_data;
                    new_min_next = 1'b1;
                end
                cnt_next = cnt_inc;
            end
        end else if ((state == REPORT) && res_ready) begin
            cnt_next = '0;
        end
    end

    // Datapath and result registers; result captured on entry to REPORT
    always_ff @(posedge clk) begin
        if (rst) begin
            max_val    <= '0;
            min_val    <= '0;
            sample_cnt <= '0;
            new_max    <= 1'b0;
            new_min    <= 1'b0;
            res_valid  <= 1'b0;
            res_max    <= '0;
            res_min    <= '0;
        end else begin
            max_val    <= max_next;
            min_val    <= min_next;
            sample_cnt <= cnt_next;
            new_max    <= new_max_next;
            new_min    <= new_min_next;
            res_valid  <= (state_next == REPORT);
            if ((state != REPORT) && (state_next == REPORT)) begin
                res_max <= max_next;
                res_min <= min_next;
            end
        end
    end

endmodule

// File: doc/window_minmax_tracker.md
# window_minmax_tracker

Sequential stage that sits downstream of the 4-bit magnitude comparator. It applies the same unsigned greater-than / less-than / equal rules to a stream of samples. Over a fixed window of accepted samples it tracks the running maximum and minimum, pulses an event when either extreme changes, and presents the window result on a valid/ready output handshake before starting the next window.

## Interface
- WIDTH, 4, sample width in bits; all comparisons are unsigned.
- WINDOW, 8, number of accepted samples per window; legal range 1..255.
- CNT_W, 8, width of the sample counter; must satisfy 2^CNT_W > WINDOW.

- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; has priority over every other input.
- clr  input  1  synchronous window abort; second priority after rst.
- in_valid  input  1  sample present on in_data.
- in_data  input  WIDTH  sample value.
- in_ready  output  1  stage can accept a sample; driven combinationally from state.
- max_val  output  WIDTH  running maximum of the current window.
- min_val  output  WIDTH  running minimum of the current window.
- sample_cnt  output  CNT_W  samples accepted in the current window.
- new_max  output  1  one-cycle pulse: the previous acceptance raised max_val.
- new_min  output  1  one-cycle pulse: the previous acceptance lowered min_val.
- res_valid  output  1  window result available.
- res_max  output  WIDTH  final window maximum; stable while res_valid is high.
- res_min  output  WIDTH  final window minimum; stable while res_valid is high.
- res_ready  input  1  consumer takes the result.

## Operation
- Accept: a sample is accepted on any edge where in_valid && in_ready.
- State IDLE (no sample yet):
  - in_ready = 1.
  - On accept: max_val = min_val = in_data, sample_cnt = 1, new_max = new_min = 1.
  - Next state is REPORT if WINDOW == 1, otherwise TRACK.
- State TRACK:
  - in_ready = 1.
  - On accept, if in_data > max_val: max_val updates and new_max pulses.
  - On accept, if in_data < min_val: min_val updates and new_min pulses.
  - If in_data equals an extreme, that extreme does not update and no pulse is generated.
  - sample_cnt increments on every accept.
  - When the accept makes sample_cnt == WINDOW, the next state is REPORT.
- State REPORT:
  - in_ready = 0; samples offered here are not accepted and must be held by the producer.
  - res_valid = 1, with res_max/res_min holding the final extremes, including the last sample.
  - On res_valid && res_ready: next state IDLE, sample_cnt = 0; max_val/min_val hold their values until the next accept.
- clr, in any state: next state IDLE, sample_cnt = 0, new_max = new_min = 0, res_valid = 0. A sample offered in the same cycle is not accepted, and no result is emitted for the aborted window.
- Arithmetic: sample_cnt never wraps, because it stops at WINDOW. Extremes are compared at full WIDTH, unsigned, with no sign extension.

## Timing
- Reset values:
  - state IDLE, so in_ready = 1 the cycle after rst deasserts.
  - max_val = 0, min_val = 0, sample_cnt = 0, new_max = 0, new_min = 0.
  - res_valid = 0, res_max = 0, res_min = 0.
- Latency:
  - max_val, min_val, sample_cnt and the new_* pulses are registered and visible in the cycle after acceptance.
  - res_valid rises in the cycle after the WINDOW-th acceptance; in_ready drops in that same cycle.
- Minimum cost per window is WINDOW + 1 cycles. This minimum holds when res_ready is already high in the first REPORT cycle and in_valid stays high.
- The result is held indefinitely while res_ready = 0.
- rst or clr asserted during REPORT drops res_valid the next cycle, even if res_ready was high.
- rst asserted mid-window discards the whole window; all outputs return to their reset values.
- new_max and new_min both pulse only on the first sample of a window. After that, at most one of them pulses per acceptance.

## Test plan
- Reset then window: rst for 2 cycles, then stream 5,3,9,9,1,7,2,4 (WINDOW = 8) with res_ready = 1.
  - Required: new_max pulses after 5 and 9 only.
  - Required: new_min pulses after 5, 3 and 1.
  - Required: res_max = 9, res_min = 1, res_valid high for exactly 1 cycle, in_ready low for exactly 1 cycle.
- Backpressure: same stream with res_ready = 0 for 4 cycles.
  - Required: res_valid held high with res_max/res_min stable.
  - Required: in_ready = 0 throughout; a held in_valid sample is not accepted until the cycle after the handshake.
- Equal and boundary values: stream of all 4'hF, then all 4'h0.
  - Required: windows report 15/15 and 0/0.
  - Required: no new_* pulses after the first sample of each window.
- clr mid-window: clr asserted after 3 samples.
  - Required: sample_cnt = 0, no res_valid.
  - Required: the next 8 samples form a complete fresh window.
- rst during REPORT: rst asserted while res_valid = 1 and res_ready = 0.
  - Required: res_valid = 0 and all outputs at reset values the next cycle; in_ready = 1 after rst deasserts.
- WINDOW = 1 build: stream 6, 2.
  - Required: each sample reports max = min = itself, with new_max and new_min both pulsing.
  - Required: in_ready alternates with res_valid.
